// File: rtl/risk_alarm.sv
// risk_alarm: 4-sample moving average of fuzzy risk results, classified into
// NORMAL / WARN / ALARM with hysteresis thresholds and a persistence filter,
// plus a saturating count of ALARM entries.
module risk_alarm #(
    parameter int unsigned WARN_ON   = 96,
    parameter int unsigned WARN_OFF  = 80,
    parameter int unsigned ALARM_ON  = 176,
    parameter int unsigned ALARM_OFF = 160,
    parameter int unsigned PERSIST   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       risk_vld,
    input  logic [7:0] risk,
    input  logic       clr_evt,
    output logic [7:0] avg,
    output logic       avg_vld,
    output logic [1:0] level,
    output logic       alarm,
    output logic       alarm_pulse,
    output logic [7:0] evt_cnt
);

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 10;
    localparam int unsigned PW = 4;

    localparam logic [DW-1:0] LP_WARN_ON   = DW'(WARN_ON);
    localparam logic [DW-1:0] LP_WARN_OFF  = DW'(WARN_OFF);
    localparam logic [DW-1:0] LP_ALARM_ON  = DW'(ALARM_ON);
    localparam logic [DW-1:0] LP_ALARM_OFF = DW'(ALARM_OFF);
    localparam logic [PW-1:0] LP_PERSIST   = PW'(PERSIST);

    localparam logic [1:0] ST_NORMAL = 2'b00;
    localparam logic [1:0] ST_WARN   = 2'b01;
    localparam logic [1:0] ST_ALARM  = 2'b10;

    logic          r_in_vld;
    logic [DW-1:0] r_in;
    logic [DW-1:0] r_w0, r_w1, r_w2, r_w3;
    logic [SW-1:0] r_sum;
    logic [DW-1:0] r_avg;
    logic          r_avg_vld;
    logic [1:0]    r_level;
    logic [PW-1:0] r_pers;
    logic [1:0]    r_tgt_q;
    logic          r_alarm;
    logic          r_alarm_pulse;
    logic [DW-1:0] r_evt_cnt;

    logic [SW-1:0] w_sum_nxt;
    logic [1:0]    w_tgt;
    logic [PW-1:0] w_pers_cnt;
    logic [1:0]    w_level_nxt;
    logic [PW-1:0] w_pers_nxt;
    logic [1:0]    w_tgt_q_nxt;
    logic          w_entry;
    logic [DW-1:0] w_evt_nxt;

    // Running sum: add the incoming sample, drop the oldest one leaving the window
    assign w_sum_nxt = r_sum + SW'(r_in) - SW'(r_w3);

    // Input capture stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_vld <= 1'b0;
            r_in     <= '0;
        end else begin
            r_in_vld <= risk_vld;
            if (risk_vld) begin
                r_in <= risk;
            end
        end
    end

    // Window shift, running sum and averaged output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w0      <= '0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            r_sum     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= r_in_vld;
            if (r_in_vld) begin
                r_w0  <= r_in;
                r_w1  <= r_w0;
                r_w2  <= r_w1;
                r_w3  <= r_w2;
                r_sum <= w_sum_nxt;
                r_avg <= w_sum_nxt[SW-1:2];
            end
        end
    end

    // Level state register with persistence tracking and event counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level       <= ST_NORMAL;
            r_pers        <= '0;
            r_tgt_q       <= ST_NORMAL;
            r_alarm       <= 1'b0;
            r_alarm_pulse <= 1'b0;
            r_evt_cnt     <= '0;
        end else begin
            r_level       <= w_level_nxt;
            r_pers        <= w_pers_nxt;
            r_tgt_q       <= w_tgt_q_nxt;
            r_alarm       <= (w_level_nxt == ST_ALARM);
            r_alarm_pulse <= w_entry;
            r_evt_cnt     <= w_evt_nxt;
        end
    end

    // Hysteresis target selection from the registered average and current level
    always_comb begin
        w_tgt = ST_NORMAL;
        case (r_level)
            ST_NORMAL: begin
                if (r_avg >= LP_ALARM_ON)     w_tgt = ST_ALARM;
                else if (r_avg >= LP_WARN_ON) w_tgt = ST_WARN;
                else                          w_tgt = ST_NORMAL;
            end
            ST_WARN: begin
                if (r_avg >= LP_ALARM_ON)     w_tgt = ST_ALARM;
                else if (r_avg < LP_WARN_OFF) w_tgt = ST_NORMAL;
                else                          w_tgt = ST_WARN;
            end
            ST_ALARM: begin
                if (r_avg < LP_WARN_OFF)       w_tgt = ST_NORMAL;
                else if (r_avg < LP_ALARM_OFF) w_tgt = ST_WARN;
                else                           w_tgt = ST_ALARM;
            end
            default: w_tgt = ST_NORMAL;
        endcase
    end

    // Persistence filter, level transition and ALARM entry counting
    always_comb begin
        w_pers_cnt  = r_pers;
        w_level_nxt = r_level;
        w_pers_nxt  = r_pers;
        w_tgt_q_nxt = r_tgt_q;
        w_entry     = 1'b0;
        w_evt_nxt   = r_evt_cnt;

        if (r_avg_vld) begin
            if (w_tgt == r_level) begin
                w_pers_cnt = '0;
            end else if ((w_tgt == r_tgt_q) && (r_pers != '0)) begin
                w_pers_cnt = r_pers + PW'(1);
            end else begin
                w_pers_cnt = PW'(1);
            end
            w_tgt_q_nxt = w_tgt;
            if (w_pers_cnt == LP_PERSIST) begin
                w_level_nxt = w_tgt;
                w_pers_nxt  = '0;
                w_entry     = (w_tgt == ST_ALARM);
            end else begin
                w_pers_nxt  = w_pers_cnt;
            end
        end

        // A clear coinciding with an entry leaves exactly that one entry counted
        if (w_entry) begin
            if (clr_evt)                  w_evt_nxt = DW'(1);
            else if (r_evt_cnt != '1)     w_evt_nxt = r_evt_cnt + DW'(1);
            else                          w_evt_nxt = r_evt_cnt;
        end else if (clr_evt) begin
            w_evt_nxt = '0;
        end
    end

    assign avg         = r_avg;
    assign avg_vld     = r_avg_vld;
    assign level       = r_level;
    assign alarm       = r_alarm;
    assign alarm_pulse = r_alarm_pulse;
    assign evt_cnt     = r_evt_cnt;

endmodule

// File: doc/risk_alarm.md
# risk_alarm

Downstream stage of the fuzzy risk evaluator: consumes each 8-bit `risk` result together with its valid strobe. It smooths the results with a 4-sample moving average and classifies the average into NORMAL / WARN / ALARM. Classification uses hysteresis thresholds and a persistence filter. It also counts ALARM entries for the host.

## Interface

Parameters:
- `WARN_ON`, 96: avg ≥ this qualifies WARN from NORMAL
- `WARN_OFF`, 80: avg < this qualifies NORMAL from WARN/ALARM
- `ALARM_ON`, 176: avg ≥ this qualifies ALARM from any level
- `ALARM_OFF`, 160: avg < this (and ≥ `WARN_OFF`) qualifies WARN from ALARM
- `PERSIST`, 3: consecutive equal targets needed to change level (1..15)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `risk_vld`  in  1  one-cycle strobe, `risk` valid (fuzzy stage's `ef`)
- `risk`  in  8  unsigned risk sample
- `clr_evt`  in  1  clears `evt_cnt`
- `avg`  out  8  registered moving average
- `avg_vld`  out  1  one-cycle pulse, `avg` updated
- `level`  out  2  00 NORMAL, 01 WARN, 10 ALARM (11 never driven)
- `alarm`  out  1  `level`==ALARM
- `alarm_pulse`  out  1  one-cycle pulse on entry to ALARM
- `evt_cnt`  out  8  saturating count of ALARM entries

## Operation

- Window: four 8-bit registers, shift in `risk` on `risk_vld`. Running sum is 10 bits (max 1020, no overflow). `avg` = sum >> 2, floor.
- Reset clears window, sum, `avg`, `avg_vld` and `level` (NORMAL). It also clears `pers`, `tgt_q`, `alarm`, `alarm_pulse` and `evt_cnt`. All outputs are 0 after reset.
- Target level is computed from the registered `avg` and the current `level`:
  - NORMAL: ALARM if avg ≥ `ALARM_ON`; else WARN if avg ≥ `WARN_ON`; else NORMAL.
  - WARN: ALARM if avg ≥ `ALARM_ON`; else NORMAL if avg < `WARN_OFF`; else WARN.
  - ALARM: NORMAL if avg < `WARN_OFF`; else WARN if avg < `ALARM_OFF`; else ALARM.
- Persistence counter `pers` (4 bits) and last target `tgt_q` are evaluated only on cycles with `avg_vld`=1:
  - target == `level`: `pers` ← 0.
  - target ≠ `level` and target == `tgt_q` with `pers` > 0: `pers` ← `pers`+1.
  - otherwise: `pers` ← 1.
  - Whenever the new `pers` value equals `PERSIST`: `level` ← target, `pers` ← 0.
  - `tgt_q` ← target on every evaluation.
- Switching pending target (e.g. WARN → ALARM) restarts the count at 1.
- Any transition into ALARM asserts `alarm_pulse` for one cycle and increments `evt_cnt`. `evt_cnt` saturates at 255.
- `clr_evt` is honoured on any cycle. If it coincides with an ALARM entry, `evt_cnt` ← 1.
- Any transition is legal, including ALARM→NORMAL and NORMAL→ALARM directly.

## Timing

- Sample accepted at edge t (`risk_vld`=1): the window and `avg` update at t+1, and `avg_vld` is high during the cycle after t+1.
- FSM evaluation uses that `avg` at edge t+2. `level`, `alarm` and `alarm_pulse` change at t+2. Total latency: 2 cycles.
- Back-to-back `risk_vld` every cycle is fully supported; the pipeline never stalls and has no backpressure.
- Gaps between samples hold all state. `avg_vld` is 0 during gaps.
- `rst_n` low at an edge overrides everything, including in-flight samples and `risk_vld` on the same edge. The first post-reset sample behaves as the first ever.
- `evt_cnt` updates on the same edge as `level`. `clr_evt` has 1-cycle effect.

## Test plan

- **Escalation, PERSIST=3:** after reset, send `risk`=200 six times back-to-back.
  - `avg` = 50, 100, 150, 200, 200, 200.
  - `level` stays NORMAL throughout; the WARN count (pers 1, 2) is restarted by the ALARM target.
  - `level`=ALARM two cycles after the 6th strobe, with `alarm_pulse` high for one cycle and `evt_cnt`=1.
- **Hysteresis and de-escalation:** from the previous state, send 170 ×4.
  - `avg` = 192, 185, 177, 170; stays ALARM.
  - Then send 0 ×5: `avg` = 127, 85, 42, 0, 0.
  - `level` returns to NORMAL after the 5th zero, never passing through WARN.
  - `alarm` is 0 at that point and `evt_cnt` stays 1.
- **Full scale:** send 255 ×4; `avg`=255 with no wrap.
- **Counter saturation and clear:** force 256 ALARM entries and check `evt_cnt` holds at 255.
  - Assert `clr_evt` on the edge of an ALARM entry and check `evt_cnt`=1.
  - Assert `clr_evt` alone and check `evt_cnt`=0.
- **Reset mid-operation:** assert `rst_n`=0 for one edge with `risk_vld`=1 and WARN pending at pers=2.
  - All outputs read 0 / NORMAL.
  - A following single 200 sample gives `avg`=50.
- **Gapped samples:** send 200 with 3 idle cycles between strobes. Results must match scenario 1, with `avg_vld` pulses one cycle wide and `level` stable during gaps.
